// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the SDRAM arbiter, its two masters and the SDRAM controller.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
);
  logic              i_Disp_Req;
  logic [1:0]        i_Disp_Command;
  logic [ADDR_W-1:0] i_Disp_Address;
  logic              o_Disp_Grant;
  logic              o_Disp_Read_Valid;

  logic              o_Proc_SDRAM_Requested;
  logic              i_Proc_SDRAM_Yield;
  logic [1:0]        i_Proc_Command;
  logic [ADDR_W-1:0] i_Proc_Address;
  logic [DATA_W-1:0] i_Proc_Data_Write;
  logic              o_Proc_Read_Valid;
  logic              o_Proc_Write_Done;

  logic [1:0]        o_Command;
  logic [ADDR_W-1:0] o_Data_Address;
  logic [DATA_W-1:0] o_Data_Write;
  logic              i_Data_Read_Valid;
  logic              i_Data_Write_Done;
  logic [DATA_W-1:0] i_Data_Read;
  logic [DATA_W-1:0] o_Data_Read;

  logic              o_Yield_Timeout;
  logic              o_Route_Error;

  modport slave (
    input  i_Disp_Req, i_Disp_Command, i_Disp_Address,
    output o_Disp_Grant, o_Disp_Read_Valid,
    output o_Proc_SDRAM_Requested,
    input  i_Proc_SDRAM_Yield, i_Proc_Command, i_Proc_Address, i_Proc_Data_Write,
    output o_Proc_Read_Valid, o_Proc_Write_Done,
    output o_Command, o_Data_Address, o_Data_Write,
    input  i_Data_Read_Valid, i_Data_Write_Done, i_Data_Read,
    output o_Data_Read, o_Yield_Timeout, o_Route_Error
  );

  modport master (
    output i_Disp_Req, i_Disp_Command, i_Disp_Address,
    input  o_Disp_Grant, o_Disp_Read_Valid,
    input  o_Proc_SDRAM_Requested,
    output i_Proc_SDRAM_Yield, i_Proc_Command, i_Proc_Address, i_Proc_Data_Write,
    input  o_Proc_Read_Valid, o_Proc_Write_Done,
    input  o_Command, o_Data_Address, o_Data_Write,
    output i_Data_Read_Valid, i_Data_Write_Done, i_Data_Read,
    input  o_Data_Read, o_Yield_Timeout, o_Route_Error
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller command port between the display fetch (priority, read-only)
// and the background processor, handing over only once the processor has yielded.
module sdram_arbiter #(
  parameter int ADDR_W        = 22,
  parameter int DATA_W        = 32,
  parameter int YIELD_TIMEOUT = 1023
) (
  input  logic           i_Clk,
  input  logic           i_Reset,
  sdram_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(YIELD_TIMEOUT + 1);

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  localparam logic [1:0] ST_PROC = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DISP = 2'd2;
  localparam logic [1:0] ST_RET  = 2'd3;

  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(YIELD_TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(YIELD_TIMEOUT - 1);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              yield_tmo;
  logic              route_err;
  logic              route_err_set;

  logic [1:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              disp_rv;
  logic              proc_rv;
  logic              proc_wd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == TMO_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      ST_PROC: if (bus.i_Disp_Req) state_next = ST_REQ;
      // A yield wins over the display withdrawing in the same cycle.
      ST_REQ: begin
        if (bus.i_Proc_SDRAM_Yield)  state_next = ST_DISP;
        else if (!bus.i_Disp_Req)    state_next = ST_PROC;
      end
      ST_DISP: if (!bus.i_Disp_Req && bus.i_Disp_Command == CMD_IDLE) state_next = ST_RET;
      ST_RET:  state_next = ST_PROC;
      default: state_next = ST_PROC;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= ST_PROC;
      tmo_cnt   <= '0;
      yield_tmo <= 1'b0;
      route_err <= 1'b0;
    end else begin
      state <= state_next;
      if (state != ST_REQ) tmo_cnt <= '0;
      else                 tmo_cnt <= sat_inc(tmo_cnt);
      // The flag only reports a stuck processor; ownership still waits for the yield.
      if (state == ST_REQ && tmo_cnt == TMO_LAST) yield_tmo <= 1'b1;
      if (route_err_set) route_err <= 1'b1;
    end
  end

  always_comb begin
    cmd           = bus.i_Proc_Command;
    addr          = bus.i_Proc_Address;
    wdata         = bus.i_Proc_Data_Write;
    disp_rv       = 1'b0;
    proc_rv       = 1'b0;
    proc_wd       = 1'b0;
    route_err_set = 1'b0;
    case (state)
      ST_PROC, ST_REQ: begin
        proc_rv = bus.i_Data_Read_Valid;
        proc_wd = bus.i_Data_Write_Done;
      end
      ST_DISP: begin
        addr    = bus.i_Disp_Address;
        wdata   = '0;
        disp_rv = bus.i_Data_Read_Valid;
        // The display path is read-only: a write is squashed rather than forwarded.
        if (bus.i_Disp_Command == CMD_WRITE) begin
          cmd           = CMD_IDLE;
          route_err_set = 1'b1;
        end else begin
          cmd = bus.i_Disp_Command;
        end
        if (bus.i_Data_Write_Done) route_err_set = 1'b1;
      end
      default: begin
        cmd           = CMD_IDLE;
        route_err_set = bus.i_Data_Read_Valid | bus.i_Data_Write_Done;
      end
    endcase
  end

  assign bus.o_Command              = cmd;
  assign bus.o_Data_Address         = addr;
  assign bus.o_Data_Write           = wdata;
  assign bus.o_Data_Read            = bus.i_Data_Read;
  assign bus.o_Disp_Grant           = (state == ST_DISP);
  assign bus.o_Proc_SDRAM_Requested = (state != ST_PROC);
  assign bus.o_Disp_Read_Valid      = disp_rv;
  assign bus.o_Proc_Read_Valid      = proc_rv;
  assign bus.o_Proc_Write_Done      = proc_wd;
  assign bus.o_Yield_Timeout        = yield_tmo;
  assign bus.o_Route_Error          = route_err;

  // CMD_READ is only passed through, never generated here.
  logic unused_read_cmd;
  assign unused_read_cmd = ^CMD_READ;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Cycle-table bench for sdram_arbiter: each row holds inputs plus expected outputs,
// queued when driven and compared mid-cycle.
module tb_sdram_arbiter;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;

  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] R = 2'd1;
  localparam logic [1:0] W = 2'd2;

  localparam logic [21:0] PA  = 22'h000010;
  localparam logic [21:0] PA2 = 22'h000020;
  localparam logic [21:0] DA  = 22'h012C00;
  localparam logic [31:0] PW  = 32'hA5A5_0001;

  localparam int SP = 0;  // processor drives the bus
  localparam int SD = 1;  // display drives the bus
  localparam int SX = 2;  // address/data not checked

  typedef struct {
    logic        rst;
    logic        dreq;
    logic [1:0]  dcmd;
    logic        yield;
    logic [1:0]  pcmd;
    logic [21:0] paddr;
    logic        rv;
    logic        wd;
    logic [6:0]  ctl;   // grant, requested, disp_rv, proc_rv, proc_wd, yield_tmo, route_err
    logic [1:0]  cmd;
    logic [21:0] addr;
    logic [31:0] wdata;
    logic        bus_chk;
    logic [31:0] rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   row_id  = 0;
  vec_t tbl[$];
  vec_t sb[$];

  sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .YIELD_TIMEOUT(7)) dut (
    .i_Clk  (clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic dr, input logic [1:0] dc,
                              input logic y, input logic [1:0] pc, input logic [21:0] pa,
                              input logic rv, input logic wd, input logic [6:0] ctl,
                              input logic [1:0] cmd, input int src);
    vec_t v;
    v.rst = r; v.dreq = dr; v.dcmd = dc; v.yield = y; v.pcmd = pc; v.paddr = pa;
    v.rv = rv; v.wd = wd; v.ctl = ctl; v.cmd = cmd;
    v.addr    = (src == SD) ? DA : pa;
    v.wdata   = (src == SD) ? 32'h0 : PW;
    v.bus_chk = (src != SX);
    v.rd      = 32'h0;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    rst                   = v.rst;
    bus.i_Disp_Req        = v.dreq;
    bus.i_Disp_Command    = v.dcmd;
    bus.i_Disp_Address    = DA;
    bus.i_Proc_SDRAM_Yield = v.yield;
    bus.i_Proc_Command    = v.pcmd;
    bus.i_Proc_Address    = v.paddr;
    bus.i_Proc_Data_Write = PW;
    bus.i_Data_Read_Valid = v.rv;
    bus.i_Data_Write_Done = v.wd;
    bus.i_Data_Read       = $urandom;
    v.rd = bus.i_Data_Read;
    sb.push_back(v);
    @(negedge clk);
    if (sb.size() == 0) begin
      check($sformatf("row%0d_queue", row_id), 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("row%0d_ctl", row_id),
            {57'd0, bus.o_Disp_Grant, bus.o_Proc_SDRAM_Requested, bus.o_Disp_Read_Valid,
             bus.o_Proc_Read_Valid, bus.o_Proc_Write_Done, bus.o_Yield_Timeout,
             bus.o_Route_Error}, {57'd0, e.ctl});
      check($sformatf("row%0d_cmd", row_id), {62'd0, bus.o_Command}, {62'd0, e.cmd});
      check($sformatf("row%0d_rdata", row_id), {32'd0, bus.o_Data_Read}, {32'd0, e.rd});
      if (e.bus_chk) begin
        check($sformatf("row%0d_addr", row_id), {42'd0, bus.o_Data_Address}, {42'd0, e.addr});
        check($sformatf("row%0d_wdata", row_id), {32'd0, bus.o_Data_Write}, {32'd0, e.wdata});
      end
    end
    row_id++;
  endtask

  initial begin
    bus.i_Disp_Req = 1'b0; bus.i_Disp_Command = I; bus.i_Disp_Address = DA;
    bus.i_Proc_SDRAM_Yield = 1'b0; bus.i_Proc_Command = R; bus.i_Proc_Address = PA;
    bus.i_Proc_Data_Write = PW; bus.i_Data_Read_Valid = 1'b0; bus.i_Data_Write_Done = 1'b0;
    bus.i_Data_Read = '0;

    // Reset, then display request during a processor read burst and handover.
    tbl.push_back(mk(1, 0, I, 0, R, PA, 0, 0, 7'b0000000, R, SP));
    tbl.push_back(mk(0, 1, R, 0, R, PA, 1, 0, 7'b0001000, R, SP));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 1, R, 0, R, PA, 1, 0, 7'b0101000, R, SP));
    tbl.push_back(mk(0, 1, R, 1, I, PA, 0, 0, 7'b0100000, I, SP));
    // Display owns the port: eight read strobes go to the display only.
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 1, R, 1, I, PA, 1, 0, 7'b1110000, R, SD));
    tbl.push_back(mk(0, 0, I, 1, I, PA, 0, 0, 7'b1100000, I, SD));
    // Guard cycle, then the processor write comes back with its done strobe.
    tbl.push_back(mk(0, 0, I, 0, W, PA2, 0, 0, 7'b0100000, I, SX));
    tbl.push_back(mk(0, 0, I, 0, W, PA2, 0, 1, 7'b0000100, W, SP));
    tbl.push_back(mk(0, 0, I, 0, I, PA2, 0, 0, 7'b0000000, I, SP));
    // Display write is squashed and flagged; reset mid-DISP clears everything at once.
    tbl.push_back(mk(0, 1, R, 0, I, PA, 0, 0, 7'b0000000, I, SP));
    tbl.push_back(mk(0, 1, R, 1, I, PA, 0, 0, 7'b0100000, I, SP));
    tbl.push_back(mk(0, 1, W, 1, I, PA, 0, 0, 7'b1100000, I, SD));
    tbl.push_back(mk(0, 1, R, 1, I, PA, 0, 0, 7'b1100001, R, SD));
    tbl.push_back(mk(1, 1, R, 1, R, PA, 0, 0, 7'b0000000, R, SP));
    // Write-done during DISP is dropped and flagged.
    tbl.push_back(mk(0, 1, R, 0, I, PA, 0, 0, 7'b0000000, I, SP));
    tbl.push_back(mk(0, 1, R, 1, I, PA, 0, 0, 7'b0100000, I, SP));
    tbl.push_back(mk(0, 1, R, 1, I, PA, 0, 1, 7'b1100000, R, SD));
    tbl.push_back(mk(0, 0, I, 1, I, PA, 0, 0, 7'b1100001, I, SD));
    tbl.push_back(mk(0, 0, I, 0, I, PA, 0, 0, 7'b0100001, I, SX));
    tbl.push_back(mk(1, 0, I, 0, I, PA, 0, 0, 7'b0000000, I, SP));
    // Processor never yields: timeout after seven REQ cycles, no grant; reset clears it.
    tbl.push_back(mk(0, 1, R, 0, R, PA, 0, 0, 7'b0000000, R, SP));
    for (int k = 0; k < 7; k++) tbl.push_back(mk(0, 1, R, 0, R, PA, 0, 0, 7'b0100000, R, SP));
    tbl.push_back(mk(0, 1, R, 0, R, PA, 0, 0, 7'b0100010, R, SP));
    tbl.push_back(mk(0, 1, R, 0, R, PA, 0, 0, 7'b0100010, R, SP));
    tbl.push_back(mk(1, 1, R, 0, R, PA, 0, 0, 7'b0000000, R, SP));

    for (int k = 0; k < tbl.size(); k++) step(tbl[k]);

    // Request withdrawn before a yield returns straight to PROC.
    step(mk(0, 1, R, 0, R, PA, 0, 0, 7'b0000000, R, SP));
    step(mk(0, 0, I, 0, R, PA, 0, 0, 7'b0100000, R, SP));
    step(mk(0, 1, R, 0, R, PA, 0, 0, 7'b0000000, R, SP));
    // Yield and withdrawal in the same cycle: yield wins, then DISP releases at once.
    step(mk(0, 0, I, 1, I, PA, 0, 0, 7'b0100000, I, SP));
    step(mk(0, 0, I, 1, I, PA, 0, 0, 7'b1100000, I, SD));
    // Strobes arriving in the guard cycle are dropped and flagged.
    step(mk(0, 0, I, 1, I, PA, 1, 1, 7'b0100000, I, SX));
    step(mk(0, 0, I, 0, W, PA2, 0, 0, 7'b0000001, W, SP));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller command port between two masters: the LCD display fetch path (priority, read-only) and the mandelbrot processor (background read/modify/write).
- The processor owns the port by default. When the display needs pixels, the processor is asked to yield through its SDRAM_Requested/Yield handshake, and the port is handed over at a burst boundary.
- Sits between both masters and the SDRAM controller. Muxes command, address and write data; routes read-valid and write-done strobes only to the current owner.

Parameters:
- ADDR_W, 22, SDRAM word address width.
- DATA_W, 32, SDRAM data width.
- YIELD_TIMEOUT, 1023, max cycles in REQ without a yield before o_Yield_Timeout is set.

Ports:
- i_Clk  in  1  system clock
- i_Reset  in  1  asynchronous, active-high reset
- i_Disp_Req  in  1  display wants the port; held until its last burst has been issued
- i_Disp_Command  in  2  display command (CMD_IDLE/CMD_READ only)
- i_Disp_Address  in  ADDR_W  display address
- o_Disp_Grant  out  1  display owns the port
- o_Disp_Read_Valid  out  1  read strobe routed to display
- o_Proc_SDRAM_Requested  out  1  asks processor to go idle and stay idle
- i_Proc_SDRAM_Yield  in  1  processor is idle and yielding
- i_Proc_Command  in  2  processor command
- i_Proc_Address  in  ADDR_W  processor address
- i_Proc_Data_Write  in  DATA_W  processor write data
- o_Proc_Read_Valid  out  1  read strobe routed to processor
- o_Proc_Write_Done  out  1  write strobe routed to processor
- o_Command  out  2  to controller
- o_Data_Address  out  ADDR_W  to controller
- o_Data_Write  out  DATA_W  to controller
- i_Data_Read_Valid  in  1  from controller
- i_Data_Write_Done  in  1  from controller
- i_Data_Read  in  DATA_W  from controller
- o_Data_Read  out  DATA_W  i_Data_Read broadcast to both masters
- o_Yield_Timeout  out  1  sticky error flag
- o_Route_Error  out  1  sticky error flag

Behaviour:
- Command encodings are CMD_IDLE/CMD_READ/CMD_WRITE from the shared sdram.vh header.
- State machine (registered, one-hot or binary):
  - PROC: processor owns the port. Next state is REQ if i_Disp_Req.
  - REQ: processor still owns the port; o_Proc_SDRAM_Requested=1.
    - i_Proc_SDRAM_Yield=1 → DISP.
    - Else i_Disp_Req=0 → PROC.
    - Yield takes precedence if both occur in the same cycle.
  - DISP: o_Disp_Grant=1; o_Proc_SDRAM_Requested=1.
    - i_Disp_Req=0 and i_Disp_Command==CMD_IDLE → RET.
    - Otherwise stay.
  - RET: one guard cycle. o_Command=CMD_IDLE, grant=0, o_Proc_SDRAM_Requested=1. Always → PROC.
- Muxing is combinational on the registered state:
  - In PROC/REQ, o_Command/o_Data_Address/o_Data_Write come from the processor. In DISP they come from the display, with o_Data_Write=0. In RET, o_Command=CMD_IDLE.
  - Strobes: in PROC/REQ, i_Data_Read_Valid → o_Proc_Read_Valid and i_Data_Write_Done → o_Proc_Write_Done. In DISP, i_Data_Read_Valid → o_Disp_Read_Valid. A strobe that cannot be routed (any strobe in RET, or a write-done in DISP) is dropped and sets o_Route_Error.
  - A display write command in DISP is forced to CMD_IDLE and sets o_Route_Error.
- Timeout counter:
  - Width clog2(YIELD_TIMEOUT+1); clears on any state other than REQ; increments each REQ cycle.
  - When it reaches YIELD_TIMEOUT, o_Yield_Timeout is set (sticky) and the FSM stays in REQ. The display is never granted over an active processor burst.
- Reset (asynchronous, any time, including mid-burst): state=PROC, counter=0, both sticky flags=0, grant=0, requested=0. Outputs follow the processor mux immediately after reset.
- Latency:
  - i_Disp_Req → o_Proc_SDRAM_Requested: 1 cycle.
  - i_Proc_SDRAM_Yield → o_Disp_Grant: 1 cycle.
  - Display release → processor regains the port: 2 cycles (DISP→RET→PROC).

Test Plan:
- Reset with processor issuing CMD_READ at address 0x000010 → o_Command=CMD_READ, o_Data_Address=0x000010, grant=0, requested=0.
- i_Disp_Req=1 while processor is mid read burst (yield=0 for 5 cycles) → requested=1 from the next cycle, processor commands still pass through. Yield=1 → grant=1 one cycle later, display address 0x012C00 appears on o_Data_Address.
- In DISP, 8 i_Data_Read_Valid pulses → 8 o_Disp_Read_Valid pulses, o_Proc_Read_Valid stays 0.
- Display drops req with command idle → one cycle of o_Command=CMD_IDLE (RET), then processor CMD_WRITE visible; o_Proc_Write_Done follows i_Data_Write_Done.
- Yield held 0 with YIELD_TIMEOUT=7 → o_Yield_Timeout=1 after 7 REQ cycles, grant stays 0. Reset clears the flag.
- i_Data_Write_Done pulse during DISP → o_Route_Error=1, no strobe on either master. Assert i_Reset mid-DISP → state PROC, grant=0 without waiting for a clock edge.
